// File: rtl/nibble_deserializer.sv
// nibble_deserializer
// Reassembles consecutive 4-bit nibbles into a NIBBLES-nibble word, first
// nibble in the most significant position, and offers each completed word
// downstream on a valid/ready handshake.
//
// Optional feature macro: DESER_PARITY_EN (adds si_par / par_err and the
// per-nibble even-parity check).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   shn        in   shift enable; si sampled only when high
//   si         in   incoming nibble
//   sof        in   start of frame; discards the partial word
//   out_word   out  assembled word (W = 4*NIBBLES bits)
//   out_valid  out  out_word is held for downstream
//   out_ready  in   downstream accepts out_word
//   nib_cnt    out  nibbles collected toward the current word
//   ovf        out  sticky: a completed word was dropped
//   clr_err    in   synchronous clear of the sticky flags
//   si_par     in   even-parity bit for si      (DESER_PARITY_EN only)
//   par_err    out  sticky parity error flag    (DESER_PARITY_EN only)
module nibble_deserializer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   shn,
  input  logic [3:0]             si,
  input  logic                   sof,
  output logic [4*NIBBLES-1:0]   out_word,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             nib_cnt,
  output logic                   ovf,
  input  logic                   clr_err
`ifdef DESER_PARITY_EN
  ,
  input  logic                   si_par,
  output logic                   par_err
`endif
);

  localparam int W = 4 * NIBBLES;
  localparam logic [2:0] LAST = 3'(NIBBLES - 1);

  typedef enum logic {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t         state_reg, state_next;
  // Only the first NIBBLES-1 nibbles need storage; the final nibble is taken
  // straight from si when the word completes.
  logic [W-5:0]   shreg_reg, shreg_next;
  logic [W-1:0]   word_reg, word_next;
  logic [2:0]     cnt_reg, cnt_next;
  logic           ovf_reg, ovf_next;
  logic           complete;
  logic           drop;
  logic [W-1:0]   full_word;

  // Collection datapath: shift register and nibble counter.
  always_comb begin
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;
    complete   = 1'b0;
    full_word  = {shreg_reg, si};
    if (shn) begin
      if (sof) begin
        // New frame: the sampled nibble is nibble 0 of a fresh word.
        shreg_next      = '0;
        shreg_next[3:0] = si;
        cnt_next        = 3'd1;
      end else if (cnt_reg == LAST) begin
        complete   = 1'b1;
        shreg_next = full_word[W-5:0];
        cnt_next   = 3'd0;
      end else begin
        shreg_next = full_word[W-5:0];
        cnt_next   = cnt_reg + 3'd1;
      end
    end else if (sof) begin
      shreg_next = '0;
      cnt_next   = 3'd0;
    end
  end

  // Output FSM: EMPTY / PENDING with single-entry holding register.
  always_comb begin
    state_next = state_reg;
    word_next  = word_reg;
    drop       = 1'b0;
    if (state_reg == EMPTY) begin
      if (complete) begin
        word_next  = full_word;
        state_next = PENDING;
      end
    end else begin
      if (complete) begin
        // Transfer and reload on the same edge keeps out_valid high.
        if (out_ready) word_next = full_word;
        else           drop      = 1'b1;
      end else if (out_ready) begin
        state_next = EMPTY;
      end
    end
    // A new error on the clearing edge wins.
    if (drop)         ovf_next = 1'b1;
    else if (clr_err) ovf_next = 1'b0;
    else              ovf_next = ovf_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= EMPTY;
      shreg_reg <= '0;
      word_reg  <= '0;
      cnt_reg   <= 3'd0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      word_reg  <= word_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign out_word  = word_reg;
  assign out_valid = (state_reg == PENDING);
  assign nib_cnt   = cnt_reg;
  assign ovf       = ovf_reg;

`ifdef DESER_PARITY_EN
  logic par_err_reg, par_err_next;

  // Parity is checked on every accepted nibble; the nibble is kept anyway.
  always_comb begin
    if (shn && (^{si, si_par})) par_err_next = 1'b1;
    else if (clr_err)           par_err_next = 1'b0;
    else                        par_err_next = par_err_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_err_reg <= 1'b0;
    else      par_err_reg <= par_err_next;
  end

  assign par_err = par_err_reg;
`endif

endmodule

// File: tb/tb_nibble_deserializer.sv
// Testbench for nibble_deserializer (NIBBLES = 4).
// A transfer-level model (queue of collected nibbles, pending word) is checked
// against the DUT on every falling edge; directed sequences add literal checks.
module tb_nibble_deserializer;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         shn = 1'b0;
  logic         sof = 1'b0;
  logic [3:0]   si = 4'h0;
  logic         out_ready = 1'b0;
  logic         clr_err = 1'b0;
  logic [W-1:0] out_word;
  logic         out_valid;
  logic [2:0]   nib_cnt;
  logic         ovf;
`ifdef DESER_PARITY_EN
  logic         si_par = 1'b0;
  logic         par_err;
`endif

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  nibble_deserializer #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .shn       (shn),
    .si        (si),
    .sof       (sof),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .nib_cnt   (nib_cnt),
    .ovf       (ovf),
    .clr_err   (clr_err)
`ifdef DESER_PARITY_EN
    ,
    .si_par    (si_par),
    .par_err   (par_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]   q[$];
  logic [W-1:0] m_word = '0;
  bit           m_valid = 1'b0;
  bit           m_ovf = 1'b0;
  bit           m_par = 1'b0;

  always @(posedge clk or negedge rst) begin
    logic [W-1:0] w;
    bit done;
    bit drop;
    bit perr;
    if (!rst) begin
      q.delete();
      m_word  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_par   = 1'b0;
    end else begin
      done = 1'b0;
      drop = 1'b0;
      perr = 1'b0;
      w    = '0;
      if (sof) q.delete();
      if (shn) begin
        q.push_back(si);
`ifdef DESER_PARITY_EN
        perr = ((si[0] + si[1] + si[2] + si[3] + si_par) % 2) != 0;
`endif
        if (q.size() == N) begin
          foreach (q[i]) w = w * 16 + W'(q[i]);
          done = 1'b1;
          q.delete();
        end
      end
      if (done) begin
        if (m_valid && !out_ready) drop = 1'b1;
        else begin
          m_word  = w;
          m_valid = 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (drop)         m_ovf = 1'b1;
      else if (clr_err) m_ovf = 1'b0;
      if (perr)         m_par = 1'b1;
      else if (clr_err) m_par = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst && chk_en) begin
      check("model_word", out_word, m_word);
      check("model_valid", out_valid, m_valid);
      check("model_cnt", nib_cnt, q.size());
      check("model_ovf", ovf, m_ovf);
`ifdef DESER_PARITY_EN
      check("model_par", par_err, m_par);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [3:0] n, input bit s);
    shn = 1'b1;
    si  = n;
    sof = s;
`ifdef DESER_PARITY_EN
    si_par = ^n;
`endif
    @(posedge clk); #1;
    shn = 1'b0;
    sof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 3; i >= 0; i--) send(w[4*i +: 4], 1'b0);
  endtask

  initial begin
    logic [15:0] pat;
    pat = 16'hA5D3;
    out_ready = 1'b1;
    idle(2);
    check("rst_word", out_word, 16'h0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_cnt", nib_cnt, 3'd0);
    check("rst_ovf", ovf, 1'b0);
    rst = 1'b1;
    chk_en = 1'b1;
    idle(1);

    // Back-to-back nibbles
    send_word(pat);
    check("t1_word", out_word, 16'hA5D3);
    check("t1_model_word", m_word, 16'hA5D3);
    check("t1_valid", out_valid, 1'b1);
    check("t1_ovf", ovf, 1'b0);
    idle(1);
    check("t1_valid_drop", out_valid, 1'b0);

    // Gaps between nibbles
    for (int i = 3; i >= 0; i--) begin
      send(pat[4*i +: 4], 1'b0);
      if (i > 0) begin
        check("t2_cnt", nib_cnt, 3'(4 - i));
        idle(3);
        check("t2_cnt_hold", nib_cnt, 3'(4 - i));
      end
    end
    check("t2_word", out_word, 16'hA5D3);
    check("t2_valid", out_valid, 1'b1);
    idle(1);

    // Overflow with downstream stalled
    out_ready = 1'b0;
    send_word(16'h1111);
    check("t3_word1", out_word, 16'h1111);
    check("t3_ovf0", ovf, 1'b0);
    send_word(16'h2222);
    check("t3_word_kept", out_word, 16'h1111);
    check("t3_ovf1", ovf, 1'b1);
    check("t3_model_ovf", m_ovf, 1'b1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    check("t3_ovf_clr", ovf, 1'b0);
    out_ready = 1'b1;
    idle(1);
    check("t3_drain", out_valid, 1'b0);

    // Start-of-frame realignment
    send(4'hF, 1'b0);
    send(4'hF, 1'b0);
    send(4'h8, 1'b1);
    check("t4_cnt_sof", nib_cnt, 3'd1);
    send(4'h0, 1'b0);
    send(4'hC, 1'b0);
    send(4'h3, 1'b0);
    check("t4_word", out_word, 16'h80C3);
    check("t4_model_word", m_word, 16'h80C3);
    idle(1);

    // Reset mid-word
    send(4'h9, 1'b0);
    send(4'h9, 1'b0);
    rst = 1'b0;
    #1;
    check("t5_rst_word", out_word, 16'h0);
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_cnt", nib_cnt, 3'd0);
    check("t5_rst_ovf", ovf, 1'b0);
    idle(2);
    rst = 1'b1;
    send_word(16'h1234);
    check("t5_word", out_word, 16'h1234);
    idle(1);

`ifdef DESER_PARITY_EN
    shn = 1'b1; si = 4'b0111; si_par = 1'b0;
    @(posedge clk); #1;
    shn = 1'b0;
    check("par_set", par_err, 1'b1);
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    check("par_word", out_word, 16'h7123);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    check("par_clr", par_err, 1'b0);
    shn = 1'b1; si = 4'b0111; si_par = 1'b1;
    @(posedge clk); #1;
    shn = 1'b0;
    check("par_ok", par_err, 1'b0);
    sof = 1'b1;
    idle(1);
    sof = 1'b0;
`endif

    // Randomised traffic, checked by the compare process
    for (int c = 0; c < 3000; c++) begin
      shn       = ($urandom_range(0, 99) < 65);
      si        = 4'($urandom);
      sof       = ($urandom_range(0, 99) < 5);
      out_ready = ($urandom_range(0, 99) < 50);
      clr_err   = ($urandom_range(0, 99) < 5);
`ifdef DESER_PARITY_EN
      si_par    = ($urandom_range(0, 99) < 90) ? ^si : ~(^si);
`endif
      @(posedge clk); #1;
    end
    shn = 1'b0; sof = 1'b0; clr_err = 1'b0; out_ready = 1'b1;
    idle(3);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_deserializer.md
# nibble_deserializer

Receive-side counterpart of the 4-bit shifter: collects consecutive 4-bit nibbles presented on a shift-enabled lane and reassembles them into a parallel word of `NIBBLES` nibbles, first nibble in the most significant position. Completed words are offered downstream on a valid/ready handshake. Framing realignment, a sticky overflow flag and optional per-nibble parity checking are included. The block sits directly after a shifter's `so` output in the datapath.

## Interface
- `NIBBLES`, default 4: nibbles per word, legal range 2..8; word width `W = 4*NIBBLES`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `shn` input 1: shift enable; `si` is sampled only on edges where `shn=1`.
- `si` input 4: incoming nibble.
- `sof` input 1: start of frame; realigns the nibble counter.
- `out_word` output W: assembled word.
- `out_valid` output 1: `out_word` is held for downstream.
- `out_ready` input 1: downstream accepts `out_word`.
- `nib_cnt` output 3: nibbles collected toward the current word, 0..NIBBLES-1.
- `ovf` output 1: sticky flag, set when a completed word was dropped.
- `clr_err` input 1: synchronous clear of `ovf` and `par_err`.
- `si_par` input 1: even-parity bit for `si`. Present only with `DESER_PARITY_EN`.
- `par_err` output 1: sticky parity error flag. Present only with `DESER_PARITY_EN`.

## Operation
- Reset (`rst=0`): shift register, `nib_cnt`, `out_word`, `out_valid`, `ovf` and `par_err` all clear to 0 immediately, independent of `clk`. Output FSM goes to EMPTY.
- Accept: on an edge with `shn=1`, `si` shifts into the low nibble of the internal shift register and `nib_cnt` increments.
- Completion: when the accepted nibble is the NIBBLES-th, the full word is complete. `nib_cnt` wraps to 0.
- Hold: on an edge with `shn=0`, the shift register and `nib_cnt` hold their values. Gaps of any length between nibbles are legal.
- `sof=1` with `shn=1`: the partial word is discarded. The sampled nibble becomes nibble 0 of a new word, and `nib_cnt` becomes 1.
- `sof=1` with `shn=0`: the partial word is discarded and `nib_cnt` becomes 0.
- Output FSM has two states, EMPTY and PENDING:
  - EMPTY + completion: `out_word` loads the word, `out_valid` goes to 1, and the FSM moves to PENDING.
  - PENDING + `out_ready=1` + no completion: `out_valid` goes to 0 and the FSM moves to EMPTY.
  - PENDING + `out_ready=1` + completion on the same edge: `out_word` loads the new word and `out_valid` stays 1. No overflow.
  - PENDING + `out_ready=0` + completion: the new word is dropped, `out_word` is unchanged, and `ovf` is set to 1.
- `out_word` holds its value while PENDING and retains the last word after EMPTY.
- `clr_err=1` clears the sticky flags on the next edge. If a new error occurs on the same edge, the error wins and the flag stays 1.

## Timing
- Latency: `out_valid` rises on the same edge that samples the final nibble. The word is visible one cycle after the last nibble is presented.
- Handshake: a transfer occurs on any edge where `out_valid=1` and `out_ready=1`. `out_word` is stable while `out_valid=1` until that transfer.
- Throughput: one word per NIBBLES enabled cycles. Back-to-back words with `out_ready` tied high give no overflow.
- Asserting `rst` mid-word discards all state. The first nibble after release is nibble 0.
- `ovf`, `par_err` and `nib_cnt` are registered outputs.

## Configuration
- `DESER_PARITY_EN` defined:
  - `si_par` and `par_err` ports exist.
  - On each accepted nibble, if `^{si, si_par} != 0`, `par_err` sets (sticky).
  - The nibble is still accepted, and the word is delivered normally.
- `DESER_PARITY_EN` undefined: both ports and all parity logic are absent. Behaviour is otherwise identical.

## Test plan
- After reset with `NIBBLES=4` and `out_ready=1`, feed `si` = A, 5, D, 3 with `shn=1` on consecutive edges -> `out_word=16'hA5D3`, `out_valid` high for exactly 1 cycle, `ovf=0`.
- Feed the same nibbles with `shn=0` for 3 cycles between each -> same `16'hA5D3`. `nib_cnt` steps 1, 2, 3 and holds during the gaps.
- With `out_ready=0`, send words `16'h1111` and then `16'h2222` -> `out_word` stays `16'h1111` and `ovf=1`. Pulse `clr_err` -> `ovf=0`.
- Send nibbles F, F, then `sof=1` with `si=8`, then 0, C, 3 -> `out_word=16'h80C3`.
- Assert `rst=0` after 2 nibbles, release, then send 1, 2, 3, 4 -> all outputs are 0 during reset, then `out_word=16'h1234`.
- With `DESER_PARITY_EN`, send `si=4'b0111` with `si_par=0` -> `par_err=1` and the word is still delivered. With `si_par=1`, `par_err` stays 0.
